mvu_agu_ctrl: RTL and testbench



---
 rtl/mvu_agu_ctrl.sv | 230 +++++++++++++++++++++++
 tb/tb_mvu_agu_ctrl.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mvu_agu_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : mvu_agu_ctrl (with helper mvu_agu_walk)
//  Purpose  : per-MVU job sequencer issuing 2-D strided weight/data read beats
//  Revision : 1.0 - initial release
// ============================================================================

module mvu_agu_walk #(
   parameter int AW = 15,
   parameter int SW = 15,
   parameter int LW = 15
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          load,
   input  logic          step,
   input  logic [AW-1:0] base,
   input  logic [SW-1:0] stride_0,
   input  logic [SW-1:0] stride_1,
   input  logic [LW-1:0] length_0,
   input  logic [LW-1:0] length_1,
   output logic [AW-1:0] addr,
   output logic          at_first,
   output logic          at_last0
);

   logic [AW-1:0] r_base;
   logic [AW-1:0] r_str0;
   logic [AW-1:0] r_str1;
   logic [LW-1:0] r_last0;
   logic [LW-1:0] r_last1;
   logic [LW-1:0] r_i0;
   logic [LW-1:0] r_i1;
   logic [AW-1:0] r_off0;
   logic [AW-1:0] r_off1;

   // A zero length behaves as a single iteration, so its last index is 0.
   function automatic logic [LW-1:0] last_idx(input logic [LW-1:0] len);
      return (len == '0) ? '0 : len - LW'(1);
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_base  <= '0;
         r_str0  <= '0;
         r_str1  <= '0;
         r_last0 <= '0;
         r_last1 <= '0;
         r_i0    <= '0;
         r_i1    <= '0;
         r_off0  <= '0;
         r_off1  <= '0;
      end else if (load) begin
         r_base  <= base;
         r_str0  <= AW'(stride_0);
         r_str1  <= AW'(stride_1);
         r_last0 <= last_idx(length_0);
         r_last1 <= last_idx(length_1);
         r_i0    <= '0;
         r_i1    <= '0;
         r_off0  <= '0;
         r_off1  <= '0;
      end else if (step) begin
         if (r_i0 == r_last0) begin
            r_i0   <= '0;
            r_off0 <= '0;
            if (r_i1 == r_last1) begin
               r_i1   <= '0;
               r_off1 <= '0;
            end else begin
               r_i1   <= r_i1 + LW'(1);
               r_off1 <= r_off1 + r_str1;
            end
         end else begin
            r_i0   <= r_i0 + LW'(1);
            r_off0 <= r_off0 + r_str0;
         end
      end
   end

   // Truncation to AW bits gives the modulo-2^AW address wrap.
   assign addr     = r_base + r_off0 + r_off1;
   assign at_first = (r_i0 == '0);
   assign at_last0 = (r_i0 == r_last0);

endmodule

module mvu_agu_ctrl #(
   parameter int BCNTDWN = 29,
   parameter int BWBANKA = 9,
   parameter int BDBANKA = 15,
   parameter int BSTRIDE = 15,
   parameter int BLENGTH = 15
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [BCNTDWN-1:0] countdown,
   input  logic [BWBANKA-1:0] wbaseaddr,
   input  logic [BSTRIDE-1:0] wstride_0,
   input  logic [BSTRIDE-1:0] wstride_1,
   input  logic [BLENGTH-1:0] wlength_0,
   input  logic [BLENGTH-1:0] wlength_1,
   input  logic [BDBANKA-1:0] ibaseaddr,
   input  logic [BSTRIDE-1:0] istride_0,
   input  logic [BSTRIDE-1:0] istride_1,
   input  logic [BLENGTH-1:0] ilength_0,
   input  logic [BLENGTH-1:0] ilength_1,
   output logic               busy,
   output logic               done,
   output logic [BWBANKA-1:0] rdw_addr,
   output logic               rdd_en,
   input  logic               rdd_grnt,
   output logic [BDBANKA-1:0] rdd_addr,
   output logic               acc_clr,
   output logic               acc_last
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t             r_state;
   logic               r_busy;
   logic               r_done;
   logic [BCNTDWN-1:0] r_rem;

   logic       w_load;
   logic       w_beat;
   logic       w_rem_one;
   logic       w_d_first;
   logic       w_d_last0;
   logic [1:0] w_unused_wflags;

   assign w_load    = (r_state == IDLE) & start;
   assign w_beat    = r_busy & rdd_grnt;
   assign w_rem_one = (r_rem == BCNTDWN'(1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_rem   <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_rem <= countdown;
                  if (countdown != '0) begin
                     r_state <= RUN;
                     r_busy  <= 1'b1;
                  end else begin
                     r_state <= DONE;
                     r_done  <= 1'b1;
                  end
               end
            end
            RUN: begin
               if (w_beat) begin
                  r_rem <= r_rem - BCNTDWN'(1);
                  if (w_rem_one) begin
                     r_state <= DONE;
                     r_busy  <= 1'b0;
                     r_done  <= 1'b1;
                  end
               end
            end
            DONE: begin
               r_state <= IDLE;
               r_done  <= 1'b0;
            end
            default: begin
               r_state <= IDLE;
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
            end
         endcase
      end
   end

   // Weight and data patterns run on independent counters, stepping together on each beat.
   mvu_agu_walk #(
      .AW (BWBANKA),
      .SW (BSTRIDE),
      .LW (BLENGTH)
   ) u_wwalk (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (w_load),
      .step     (w_beat),
      .base     (wbaseaddr),
      .stride_0 (wstride_0),
      .stride_1 (wstride_1),
      .length_0 (wlength_0),
      .length_1 (wlength_1),
      .addr     (rdw_addr),
      .at_first (w_unused_wflags[0]),
      .at_last0 (w_unused_wflags[1])
   );

   mvu_agu_walk #(
      .AW (BDBANKA),
      .SW (BSTRIDE),
      .LW (BLENGTH)
   ) u_dwalk (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (w_load),
      .step     (w_beat),
      .base     (ibaseaddr),
      .stride_0 (istride_0),
      .stride_1 (istride_1),
      .length_0 (ilength_0),
      .length_1 (ilength_1),
      .addr     (rdd_addr),
      .at_first (w_d_first),
      .at_last0 (w_d_last0)
   );

   assign busy     = r_busy;
   assign done     = r_done;
   assign rdd_en   = r_busy;
   assign acc_clr  = w_beat & w_d_first;
   assign acc_last = w_beat & (w_d_last0 | w_rem_one);

endmodule
`default_nettype wire

// File: tb/tb_mvu_agu_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mvu_agu_ctrl
//  Purpose  : scoreboard bench for mvu_agu_ctrl using directed job vectors
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mvu_agu_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [28:0] countdown = '0;
   logic [8:0]  wbaseaddr = '0;
   logic [14:0] wstride_0 = '0, wstride_1 = '0, wlength_0 = '0, wlength_1 = '0;
   logic [14:0] ibaseaddr = '0;
   logic [14:0] istride_0 = '0, istride_1 = '0, ilength_0 = '0, ilength_1 = '0;
   logic        busy, done, rdd_en, acc_clr, acc_last;
   logic        rdd_grnt = 1'b1;
   logic [8:0]  rdw_addr;
   logic [14:0] rdd_addr;

   mvu_agu_ctrl dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .countdown (countdown),
      .wbaseaddr (wbaseaddr),
      .wstride_0 (wstride_0),
      .wstride_1 (wstride_1),
      .wlength_0 (wlength_0),
      .wlength_1 (wlength_1),
      .ibaseaddr (ibaseaddr),
      .istride_0 (istride_0),
      .istride_1 (istride_1),
      .ilength_0 (ilength_0),
      .ilength_1 (ilength_1),
      .busy      (busy),
      .done      (done),
      .rdw_addr  (rdw_addr),
      .rdd_en    (rdd_en),
      .rdd_grnt  (rdd_grnt),
      .rdd_addr  (rdd_addr),
      .acc_clr   (acc_clr),
      .acc_last  (acc_last)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [14:0] d;
      logic [8:0]  w;
      logic        clr;
      logic        last;
   } beat_t;

   beat_t exp_q[$];
   int    done_q[$];
   int    n_tests = 0;
   int    n_fail = 0;
   int    cyc = 0;
   beat_t e;
   int    ed;

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: pops the scoreboard on every beat and every done pulse.
   always @(negedge clk) begin
      if (rst_n) begin
         if (rdd_en) begin
            if (exp_q.size() == 0) begin
               n_tests++; n_fail++;
               $display("FAIL stray_rdd_en cyc=%0d got rdd_en=1 required 0", cyc);
            end else if (rdd_grnt) begin
               e = exp_q.pop_front();
               n_tests++;
               if (rdd_addr !== e.d || rdw_addr !== e.w || acc_clr !== e.clr || acc_last !== e.last) begin
                  n_fail++;
                  $display("FAIL beat cyc=%0d got d=%0d w=%0d clr=%b last=%b required d=%0d w=%0d clr=%b last=%b",
                           cyc, rdd_addr, rdw_addr, acc_clr, acc_last, e.d, e.w, e.clr, e.last);
               end
            end else begin
               e = exp_q[0];
               n_tests++;
               if (rdd_addr !== e.d || rdw_addr !== e.w || acc_clr !== 1'b0 || acc_last !== 1'b0) begin
                  n_fail++;
                  $display("FAIL stall cyc=%0d got d=%0d w=%0d clr=%b last=%b required d=%0d w=%0d clr=0 last=0",
                           cyc, rdd_addr, rdw_addr, acc_clr, acc_last, e.d, e.w);
               end
            end
         end
         if (done) begin
            n_tests++;
            if (done_q.size() == 0) begin
               n_fail++;
               $display("FAIL stray_done cyc=%0d got done=1 required 0", cyc);
            end else begin
               ed = done_q.pop_front();
               if (cyc != ed || busy !== 1'b0) begin
                  n_fail++;
                  $display("FAIL done_timing got cyc=%0d busy=%b required cyc=%0d busy=0", cyc, busy, ed);
               end
            end
         end
      end
   end

   task automatic push(input int d, input int w, input bit clr, input bit last);
      beat_t b;
      b.d = d[14:0]; b.w = w[8:0]; b.clr = clr; b.last = last;
      exp_q.push_back(b);
   endtask

   task automatic set_cfg(input int cnt, input int wb, input int ws0, input int ws1, input int wl0,
                          input int wl1, input int ib, input int is0, input int is1, input int il0,
                          input int il1);
      countdown = cnt[28:0];
      wbaseaddr = wb[8:0];  wstride_0 = ws0[14:0]; wstride_1 = ws1[14:0];
      wlength_0 = wl0[14:0]; wlength_1 = wl1[14:0];
      ibaseaddr = ib[14:0]; istride_0 = is0[14:0]; istride_1 = is1[14:0];
      ilength_0 = il0[14:0]; ilength_1 = il1[14:0];
   endtask

   // Issues start for one cycle; the expected done cycle counts from the accepting edge.
   task automatic start_job(input int cnt, input int stalls);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      done_q.push_back(cyc + cnt + stalls);
   endtask

   task automatic wait_job(input int bound);
      int k = 0;
      while (done_q.size() != 0 && k < bound) begin
         @(posedge clk); #1;
         k++;
      end
      n_tests++;
      if (done_q.size() != 0 || exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL job_complete got pending_done=%0d pending_beats=%0d required 0/0",
                  done_q.size(), exp_q.size());
         done_q.delete();
         exp_q.delete();
      end
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic check_zero(input string tag);
      n_tests++;
      if ({busy, done, rdd_en, acc_clr, acc_last} !== 5'b0 || rdw_addr !== 9'd0 || rdd_addr !== 15'd0) begin
         n_fail++;
         $display("FAIL %s got busy=%b done=%b en=%b clr=%b last=%b w=%0d d=%0d required all 0",
                  tag, busy, done, rdd_en, acc_clr, acc_last, rdw_addr, rdd_addr);
      end
   endtask

   task automatic push_job2();
      push(0, 5, 1, 0); push(1, 12, 0, 1); push(16, 19, 1, 0); push(17, 5, 0, 1); push(0, 12, 1, 1);
      set_cfg(5, 5, 3, 7, 0, 3, 0, 1, 16, 2, 2);
   endtask

   task automatic push_job1(input int cnt);
      push(100, 0, 1, 0); push(102, 1, 0, 0); push(104, 2, 0, 1);
      push(100, 3, 1, 0); push(102, 0, 0, 0); push(104, 1, 0, 1);
      set_cfg(cnt, 0, 1, 0, 4, 1, 100, 2, 0, 3, 1);
   endtask

   initial begin
      #1;
      check_zero("reset_state");
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;

      // 1-D data and weight patterns with continuous grant
      push_job1(6);
      start_job(6, 0);
      wait_job(100);

      // 2-D data pattern; zero-length weight dim 0 behaves as length 1
      push_job2();
      start_job(5, 0);
      wait_job(100);

      // Grant withheld 3 cycles; mid-job start and config changes are ignored
      push_job1(6);
      start_job(6, 3);
      repeat (2) @(posedge clk);
      #1;
      rdd_grnt = 1'b0; start = 1'b1; ibaseaddr = 15'd7; countdown = 29'd3;
      repeat (3) @(posedge clk);
      #1;
      rdd_grnt = 1'b1; start = 1'b0;
      wait_job(100);

      // Zero countdown: done only; start held through DONE cycle is not re-accepted
      set_cfg(0, 0, 1, 0, 1, 1, 0, 1, 0, 1, 1);
      start = 1'b1;
      @(posedge clk); #1;
      done_q.push_back(cyc);
      @(posedge clk); #1;
      start = 1'b0;
      wait_job(20);
      repeat (4) @(posedge clk);
      #1;

      // Address wrap in both banks
      push(32760, 510, 1, 0); push(32765, 511, 0, 0); push(2, 0, 0, 1);
      set_cfg(3, 510, 1, 0, 5, 1, 32760, 5, 0, 3, 1);
      start_job(3, 0);
      wait_job(100);

      // Reset during beat 2 aborts the job, then a fresh job runs from beat 0
      push(100, 0, 1, 0); push(102, 1, 0, 0);
      set_cfg(10, 0, 1, 0, 4, 1, 100, 2, 0, 3, 1);
      start_job(10, 0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b0;
      exp_q.delete();
      done_q.delete();
      #1;
      check_zero("reset_abort");
      @(posedge clk); #1;
      check_zero("reset_hold");
      rst_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      push_job2();
      start_job(5, 0);
      wait_job(100);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got timeout required completion");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
